// File: rtl/ad9245_capture.sv
// ad9245_capture: triggered capture buffer for the AD9245 14-bit sample stream.
//
// The sample stream is registered twice (d0, d1). Software arms the block
// through the Avalon-MM CTRL register. The trigger is either immediate or a
// rising threshold crossing. After the trigger, the block stores a
// programmable number of samples into an on-chip buffer, then raises done.
// The processor reads the buffer and the registers with a fixed read
// latency of one cycle.
//
// Optional feature macro: AD9245_CAPTURE_DECIM_EN
//   When defined, register 3 holds a 16-bit decimation factor N. In that
//   case, one sample in N+1 is stored during capture. When undefined, every
//   cycle stores a sample, DECIM writes are ignored, and no decimation
//   counter exists.
//
// Parameters:
//   ADDR_W      buffer address width, DEPTH = 2**ADDR_W samples
// Ports:
//   clk         system / Avalon clock; ad_data is synchronous to it
//   reset       synchronous active-high reset
//   ad_data     14-bit unsigned offset-binary ADC sample
//   chipselect  Avalon chipselect
//   read        Avalon read strobe
//   write       Avalon write strobe
//   address     [ADDR_W]=1: buffer word [ADDR_W-1:0]; [ADDR_W]=0: register [1:0]
//   writedata   Avalon write data
//   readdata    Avalon read data, valid the cycle after the read, held until next read
//   irq         level interrupt, done & irq_en
//
// Register map (word index):
//   0 CTRL/STATUS  W: bit0 arm, bit1 abort, bit2 trig_mode, bit3 irq_en
//                  R: {26'h0, irq_en, trig_mode, done, state[1:0], 1'b0}
//   1 THRESH       [13:0] R/W
//   2 LENGTH       [ADDR_W:0] R/W; 0 or > DEPTH selects DEPTH
//   3 DECIM/COUNT  W: decimation factor (optional); R: samples written

module ad9245_capture #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [13:0]       ad_data,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W:0]   address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  // DEPTH expressed in the LENGTH/count width.
  localparam logic [ADDR_W:0] DepthLen = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e            state;
  logic              done;
  logic              trig_mode;
  logic              irq_en;
  logic [13:0]       thresh;
  logic [ADDR_W:0]   cap_len;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic [13:0]       d0;
  logic [13:0]       d1;

  logic [13:0]       mem [DEPTH];

`ifdef AD9245_CAPTURE_DECIM_EN
  logic [15:0]       decim;
  logic [15:0]       dcnt;
  logic [15:0]       dcnt_next;
`endif

  logic              reg_wr;
  logic              ctrl_wr;
  logic              arm_cmd;
  logic              abort_cmd;
  logic [ADDR_W:0]   eff_len;
  logic              crossing;
  logic              trig_hit;
  logic              slot_open;
  logic              store;
  logic [ADDR_W:0]   count_inc;
  logic              last;
  logic [31:0]       reg_rdata;

  // Not every writedata bit lands in a register.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  always_comb begin
    reg_wr    = chipselect & write & ~address[ADDR_W];
    ctrl_wr   = reg_wr & (address[1:0] == 2'd0);
    // Abort beats arm when both are written together.
    abort_cmd = ctrl_wr & writedata[1];
    arm_cmd   = ctrl_wr & writedata[0] & ~writedata[1];

    eff_len   = ((cap_len == '0) || (cap_len > DepthLen)) ? DepthLen : cap_len;

    // Rising crossing on the undecimated stream.
    crossing  = (d1 < thresh) && (d0 >= thresh);
    trig_hit  = ~trig_mode | crossing;

`ifdef AD9245_CAPTURE_DECIM_EN
    slot_open = (dcnt == 16'd0);
    // >= keeps the counter bounded if DECIM is lowered mid-capture.
    dcnt_next = (dcnt >= decim) ? 16'd0 : dcnt + 16'd1;
`else
    slot_open = 1'b1;
`endif

    // The trigger sample is written on the trigger edge itself. An abort or
    // reset on the same edge wins over the write.
    store     = ~reset & ~abort_cmd &
                (((state == StArmed) & trig_hit) | ((state == StCapture) & slot_open));

    count_inc = count + 1'b1;
    last      = (count_inc == eff_len);
  end

  always_comb begin
    reg_rdata = 32'h0;
    unique case (address[1:0])
      2'd0:    reg_rdata = {26'h0, irq_en, trig_mode, done, state, 1'b0};
      2'd1:    reg_rdata = {18'h0, thresh};
      2'd2:    reg_rdata = {{(31 - ADDR_W){1'b0}}, cap_len};
      2'd3:    reg_rdata = {{(31 - ADDR_W){1'b0}}, count};
      default: reg_rdata = 32'h0;
    endcase
  end

  // Control registers, sample pipeline and capture state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      done      <= 1'b0;
      trig_mode <= 1'b0;
      irq_en    <= 1'b0;
      thresh    <= '0;
      cap_len   <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      d0        <= '0;
      d1        <= '0;
`ifdef AD9245_CAPTURE_DECIM_EN
      decim     <= '0;
      dcnt      <= '0;
`endif
    end else begin
      d0 <= ad_data;
      d1 <= d0;

      if (reg_wr) begin
        unique case (address[1:0])
          2'd0: begin
            trig_mode <= writedata[2];
            irq_en    <= writedata[3];
          end
          2'd1: thresh  <= writedata[13:0];
          2'd2: cap_len <= writedata[ADDR_W:0];
          2'd3: begin
`ifdef AD9245_CAPTURE_DECIM_EN
            decim <= writedata[15:0];
`endif
          end
          default: ;
        endcase
      end

      if (abort_cmd) begin
        state <= StIdle;
        done  <= 1'b0;
      end else begin
        unique case (state)
          StIdle, StDone: begin
            if (arm_cmd) begin
              state  <= StArmed;
              wr_ptr <= '0;
              count  <= '0;
              done   <= 1'b0;
`ifdef AD9245_CAPTURE_DECIM_EN
              dcnt   <= '0;
`endif
            end
          end
          // A repeated arm is ignored here.
          StArmed, StCapture: begin
            if (store) begin
              wr_ptr <= wr_ptr + 1'b1;
              count  <= count_inc;
              if (last) begin
                state <= StDone;
                done  <= 1'b1;
              end else begin
                state <= StCapture;
              end
            end
`ifdef AD9245_CAPTURE_DECIM_EN
            // The counter is 0 in ARMED, so it restarts from the trigger write.
            if (store || (state == StCapture)) begin
              dcnt <= dcnt_next;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Sample buffer: survives reset and arm.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= d0;
    end
  end

  // Read port: one-cycle latency, held until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'h0;
    end else if (chipselect & read) begin
      readdata <= address[ADDR_W] ? {18'h0, mem[address[ADDR_W-1:0]]} : reg_rdata;
    end
  end

  assign irq = done & irq_en;

endmodule
